// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the shared 64x32 data memory (option: DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic              lock0_i,
    input  logic              lock1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_d_o,
    input  logic [DATA_W-1:0] mem_d_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    // Count value at which a locked burst is force-released (burst length = MAX_BURST).
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    localparam bit         CAN_LOCK   = (MAX_BURST > 1);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       gnt0, gnt1;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Round-robin pointer: 0 favours port 0, 1 favours port 1 when both request in IDLE.
    logic       prio_q, prio_d;
`endif

    // Grant selection; everything is masked while reset is held so no memory access can occur.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gnt0 = req0_i;
            gnt1 = req1_i & ~req0_i;
`else
            if (req0_i && req1_i) begin
                case (state_q)
                    LOCK0:   gnt0 = 1'b1;
                    LOCK1:   gnt1 = 1'b1;
                    default: begin
                        if (prio_q) gnt1 = 1'b1;
                        else        gnt0 = 1'b1;
                    end
                endcase
            end else begin
                gnt0 = req0_i;
                gnt1 = req1_i;
            end
`endif
        end
    end

    // Mux the granted port onto the memory bus; idle bus drives zeros.
    always_comb begin
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_d_o     = '0;
        if (gnt0) begin
            mem_rd_en_o = ~we0_i;
            mem_wr_en_o = we0_i;
            mem_addr_o  = addr0_i;
            mem_d_o     = wdata0_i;
        end else if (gnt1) begin
            mem_rd_en_o = ~we1_i;
            mem_wr_en_o = we1_i;
            mem_addr_o  = addr1_i;
            mem_d_o     = wdata1_i;
        end
    end

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Burst ownership with port 0 dominant: port 0 bursts are unbounded, port 1 yields to any port 0 request.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (gnt0 && lock0_i) begin
                    state_d = LOCK0;
                    count_d = 4'd1;
                end else if (gnt1 && lock1_i && CAN_LOCK) begin
                    state_d = LOCK1;
                    count_d = 4'd1;
                end
            end
            LOCK0: begin
                if (!(gnt0 && lock0_i)) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end
            end
            LOCK1: begin
                if (gnt1 && lock1_i && !req0_i && (count_q < BURST_LAST)) begin
                    count_d = count_q + 4'd1;
                end else begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end
`else
    // Burst ownership and round-robin pointer update; a grant that leaves no owner hands priority to the other port.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (gnt0) begin
                    if (lock0_i && CAN_LOCK) begin
                        state_d = LOCK0;
                        count_d = 4'd1;
                    end else begin
                        prio_d = 1'b1;
                    end
                end else if (gnt1) begin
                    if (lock1_i && CAN_LOCK) begin
                        state_d = LOCK1;
                        count_d = 4'd1;
                    end else begin
                        prio_d = 1'b0;
                    end
                end
            end
            LOCK0: begin
                if (gnt0 && lock0_i && (count_q < BURST_LAST)) begin
                    count_d = count_q + 4'd1;
                end else begin
                    state_d = IDLE;
                    count_d = 4'd0;
                    if (gnt0)      prio_d = 1'b1;
                    else if (gnt1) prio_d = 1'b0;
                end
            end
            LOCK1: begin
                if (gnt1 && lock1_i && (count_q < BURST_LAST)) begin
                    count_d = count_q + 4'd1;
                end else begin
                    state_d = IDLE;
                    count_d = 4'd0;
                    if (gnt1)      prio_d = 1'b0;
                    else if (gnt0) prio_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end
`endif

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 4'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            prio_q  <= prio_d;
`endif
        end
    end

    // Capture asynchronous read data at the end of the grant cycle for a uniform one-cycle latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
            rdata0_o  <= '0;
            rdata1_o  <= '0;
        end else begin
            rvalid0_o <= gnt0 & ~we0_i;
            rvalid1_o <= gnt1 & ~we1_i;
            if (gnt0 && !we0_i) rdata0_o <= mem_d_i;
            if (gnt1 && !we1_i) rdata1_o <= mem_d_i;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [5:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_rd_en, mem_wr_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_d_o, mem_d_i;

    logic [31:0] mem [64];
    logic [31:0] pre [4] = '{32'd17, 32'd9, 32'd25, 32'd33};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_d_o;
    end
    assign mem_d_i = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_i      (req0),
        .req1_i      (req1),
        .we0_i       (we0),
        .we1_i       (we1),
        .lock0_i     (lock0),
        .lock1_i     (lock1),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1),
        .mem_rd_en_o (mem_rd_en),
        .mem_wr_en_o (mem_wr_en),
        .mem_addr_o  (mem_addr),
        .mem_d_o     (mem_d_o),
        .mem_d_i     (mem_d_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        req0 = 1'b1;
        #1 chk("rst_gnt0_masked", {31'd0, gnt0}, 32'd0);
        clr();
        rst_n = 1'b1;

        // preload mem[0..3] through port 1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clr();
            req1 = 1'b1; we1 = 1'b1; addr1 = 6'(i); wdata1 = pre[i];
        end

        // single port 0 read
        @(negedge clk);
        clr();
        req0 = 1'b1; addr0 = 6'd1;
        #1;
        chk("rd0_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd0_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rd0_rden", {31'd0, mem_rd_en}, 32'd1);
        chk("rd0_addr", {26'd0, mem_addr}, 32'd1);
        @(negedge clk);
        chk("rd0_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("rd0_rdata0", rdata0, 32'd9);
        chk("rd0_rvalid1", {31'd0, rvalid1}, 32'd0);
        clr();
        req1 = 1'b1; addr1 = 6'd2;
        #1 chk("rd1_gnt1", {31'd0, gnt1}, 32'd1);
        @(negedge clk);
        chk("rd1_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("rd1_rdata1", rdata1, 32'd25);
        chk("rd1_rvalid0", {31'd0, rvalid0}, 32'd0);

`ifndef DMEM_ARB_FIXED_PRIO_EN
        // contention without lock alternates 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            clr();
            req0 = 1'b1; addr0 = 6'd0; req1 = 1'b1; addr1 = 6'd2;
            #1;
            chk($sformatf("rr_gnt0_%0d", k), {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_gnt1_%0d", k), {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
            chk($sformatf("rr_rvalid0_%0d", k), {31'd0, rvalid0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_rvalid1_%0d", k), {31'd0, rvalid1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk($sformatf("rr_rdata0_%0d", k), rdata0, 32'd17);
            else            chk($sformatf("rr_rdata1_%0d", k), rdata1, 32'd25);
        end
`endif

        // port 1 write then port 0 read-after-write
        clr();
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd5; wdata1 = 32'hDEADBEEF;
        #1;
        chk("wr1_gnt1", {31'd0, gnt1}, 32'd1);
        chk("wr1_wren", {31'd0, mem_wr_en}, 32'd1);
        chk("wr1_rden", {31'd0, mem_rd_en}, 32'd0);
        chk("wr1_addr", {26'd0, mem_addr}, 32'd5);
        chk("wr1_data", mem_d_o, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr1_no_rvalid", {31'd0, rvalid1}, 32'd0);
        clr();
        req0 = 1'b1; addr0 = 6'd5;
        #1 chk("raw_gnt0", {31'd0, gnt0}, 32'd1);
        @(negedge clk);
        chk("raw_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("raw_rdata0", rdata0, 32'hDEADBEEF);

`ifndef DMEM_ARB_FIXED_PRIO_EN
        // hand priority back to port 0 with a lone port 1 read
        clr();
        req1 = 1'b1; addr1 = 6'd0;
        @(negedge clk);
        chk("pre_lock_rdata1", rdata1, 32'd17);
        // port 0 locked burst against continuous port 1: 0,0,0,0,1,0 then owner drops req
        for (int k = 0; k < 7; k++) begin
            clr();
            if (k < 6) begin
                req0 = 1'b1; lock0 = 1'b1; addr0 = 6'd1;
            end
            req1 = 1'b1; addr1 = 6'd2;
            #1;
            chk($sformatf("lock_gnt0_%0d", k), {31'd0, gnt0}, (k < 6 && k != 4) ? 32'd1 : 32'd0);
            chk($sformatf("lock_gnt1_%0d", k), {31'd0, gnt1}, (k == 4 || k == 6) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
`endif

        // port 0 read leaves priority with port 1, then a write attempted during reset
        clr();
        req0 = 1'b1; addr0 = 6'd2;
        @(negedge clk);
        clr();
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; wdata0 = 32'h12345678;
        #1;
        chk("rstwr_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rstwr_wren", {31'd0, mem_wr_en}, 32'd0);
        chk("rstwr_rden", {31'd0, mem_rd_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstwr_mem3", mem[3], 32'd33);
        chk("rst2_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst2_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst2_rdata0", rdata0, 32'd0);
        chk("rst2_rdata1", rdata1, 32'd0);
        clr();
        req0 = 1'b1; addr0 = 6'd1; req1 = 1'b1; addr1 = 6'd2;
        #1;
        chk("rst2_prio_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rst2_prio_gnt1", {31'd0, gnt1}, 32'd0);
        @(negedge clk);

`ifdef DMEM_ARB_FIXED_PRIO_EN
        // fixed priority: port 0 wins every contended cycle
        for (int k = 0; k < 6; k++) begin
            clr();
            req0 = 1'b1; addr0 = 6'd0; req1 = 1'b1; addr1 = 6'd2;
            #1;
            chk($sformatf("fix_gnt0_%0d", k), {31'd0, gnt0}, 32'd1);
            chk($sformatf("fix_gnt1_%0d", k), {31'd0, gnt1}, 32'd0);
            @(negedge clk);
        end
`endif

        clr();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port 64x32 data memory (async read, sync write).
- Port 0 is the core load/store unit. Port 1 is a secondary master (debug loader / DMA).
- Grants one access per cycle using round-robin priority, with optional bounded burst locking.
- Registers read data so requesters see a uniform one-cycle read latency.

Parameters:
- ADDR_W, 6, word address width; must match the memory depth of 64 words.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive locked grants to one port before a forced release; legal range 1..15.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- req0_i / req1_i  input  1  access request, port 0 / port 1.
- we0_i / we1_i  input  1  1 = write, 0 = read.
- lock0_i / lock1_i  input  1  request to keep ownership on the next cycle (burst).
- addr0_i / addr1_i  input  ADDR_W  word address.
- wdata0_i / wdata1_i  input  DATA_W  write data.
- gnt0_o / gnt1_o  output  1  combinational grant; the access is performed this cycle.
- rvalid0_o / rvalid1_o  output  1  one-cycle pulse; rdataN_o is valid.
- rdata0_o / rdata1_o  output  DATA_W  registered read data.
- mem_rd_en_o  output  1  memory read enable.
- mem_wr_en_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  memory address.
- mem_d_o  output  DATA_W  memory write data.
- mem_d_i  input  DATA_W  memory read data (asynchronous).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE, prio pointer = port 0, burst count = 0.
  - rvalid0_o / rvalid1_o = 0; rdata0_o / rdata1_o = 0.
  - While rst_n is low, gnt*, mem_rd_en_o and mem_wr_en_o are forced to 0, so no memory write can occur.
- Reset mid-operation: a pending rvalid is dropped; lock and burst state are cleared.
- Arbitration (combinational, same cycle):
  - At most one grant per cycle.
  - If only one port requests, that port is granted.
  - If both request, the owner (in a LOCK state) wins; in IDLE the prio pointer wins.
  - No request: no grant, all memory enables 0.
- Memory drive:
  - The granted port's addr/wdata are muxed onto mem_addr_o / mem_d_o.
  - mem_wr_en_o = grant & we; mem_rd_en_o = grant & ~we.
  - With no grant, mem_addr_o and mem_d_o are 0.
- Write: commits at the edge ending the grant cycle; no response pulse.
- Read: mem_d_i is captured at the edge ending the grant cycle; rvalidN_o = 1 for exactly the following cycle (latency 1).
  - rdataN_o holds its value until the next read completion on that port.
- Back-to-back reads on one port produce back-to-back rvalid pulses.
- Read-after-write to the same address in consecutive cycles returns the new data.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE -> LOCKn: port n granted with lockn_i = 1 and MAX_BURST > 1; count = 1.
  - LOCKn -> LOCKn: portn granted with lockn_i = 1 and count < MAX_BURST-1; count++.
  - LOCKn -> IDLE: lockn_i = 0, reqn_i = 0, or count reaches MAX_BURST-1 (forced release); count = 0.
  - If the owner drops req while in LOCKn, the other port may be granted that same cycle.
- Prio pointer:
  - On any grant that ends ownership (unlocked grant or release), the pointer moves to the non-granted port.
  - Unchanged when there is no grant.
- Starvation bound: a continuously requesting port is granted within MAX_BURST+1 cycles.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined:
  - Port 0 always wins contention; the prio pointer is removed.
  - lock1_i is honoured only when req0_i is low.
  - lock0_i bursts are unbounded (no forced release for port 0).
- Undefined: round-robin with MAX_BURST-bounded locking as described above.

Test Plan:
- Reset, then preload mem[0..2] = 17, 9, 25. Port 0 reads addr 1 -> gnt0_o same cycle; next cycle rvalid0_o = 1, rdata0_o = 9; rvalid1_o = 0.
- Both ports read (addr 0 / addr 2) for 4 cycles, no lock -> grants alternate 0,1,0,1; rdata0_o = 17, rdata1_o = 25, each one cycle after its grant.
- Port 1 writes 0xDEADBEEF to addr 5, then port 0 reads addr 5 the next cycle -> rdata0_o = 0xDEADBEEF.
- MAX_BURST = 4, port 0 holds req and lock, port 1 requests continuously -> gnt0_o for 4 cycles, then gnt1_o on cycle 5.
- Port 0 write to addr 3 with rst_n = 0 for that cycle -> mem_wr_en_o = 0 and mem[3] unchanged; after reset all rvalid/rdata = 0 and the prio pointer favours port 0.
- With DMEM_ARB_FIXED_PRIO_EN, both ports request for 6 cycles -> gnt0_o every cycle, gnt1_o never.
